// File: rtl/ddr_resp_pkg.sv
// ddr_resp_pkg: command encodings, burst size and FSM state type shared by ddr_responder
package ddr_resp_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ = 3'b001;
  localparam int BURST_BEATS = 2;
  typedef enum logic [2:0] {IDLE, WR0, WR1, RD_WAIT, RD0, RD1} state_t;
endpackage

// File: rtl/ddr_responder_if.sv
// ddr_responder_if: af/wdf/rdf request bundle between a requester (master) and ddr_responder (slave)
interface ddr_responder_if;
  logic [30:0] af_addr_din;
  logic [2:0] af_cmd_din;
  logic af_wr_en;
  logic af_full;
  logic [127:0] wdf_din;
  logic [15:0] wdf_mask_din;
  logic wdf_wr_en;
  logic wdf_full;
  logic rdf_valid;
  logic [127:0] rdf_dout;
  logic rdf_rd_en;
  modport master(
    output af_addr_din, af_cmd_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, rdf_rd_en,
    input af_full, wdf_full, rdf_valid, rdf_dout
  );
  modport slave(
    input af_addr_din, af_cmd_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, rdf_rd_en,
    output af_full, wdf_full, rdf_valid, rdf_dout
  );
endinterface

// File: rtl/ddr_responder_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a registered full flag; pushes while full are dropped
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               din,
  input  logic                       rd_en,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count_nx;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign empty = count == '0;
  assign dout = mem[rp];
  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count_nx;
      full <= count_nx == (AW+1)'(DEPTH);
    end
endmodule

// File: rtl/ddr_responder.sv
// ddr_responder: on-chip DRAM stand-in for the af/wdf/rdf protocol, 2-beat bursts into byte-masked RAM.
// Define DDR_RESP_STATS_EN to add burst counters and sticky error flags.
module ddr_responder
  import ddr_resp_pkg::*;
#(
  parameter int AF_DEPTH = 8,
  parameter int WDF_DEPTH = 16,
  parameter int MEM_AW = 10,
  parameter int RD_LATENCY = 4
) (
  input logic clk,
  input logic rst,
  ddr_responder_if.slave bus
`ifdef DDR_RESP_STATS_EN
  ,
  output logic [31:0] stat_wr_bursts,
  output logic [31:0] stat_rd_bursts,
  output logic [2:0] err_sticky
`endif
);
  localparam int AFW = $clog2(AF_DEPTH);
  localparam int WDW = $clog2(WDF_DEPTH);
  localparam int CW = $clog2(RD_LATENCY + 1);
  state_t state;
  logic [30:0] af_addr;
  logic [2:0] af_cmd;
  logic af_empty;
  logic [AFW:0] af_cnt;
  logic [127:0] wdf_data;
  logic [15:0] wdf_mask;
  logic wdf_empty;
  logic [WDW:0] wdf_cnt;
  logic af_pop, wdf_pop;
  logic [MEM_AW-1:0] idx, af_idx;
  logic [CW-1:0] cnt;
  logic rd_valid;
  logic [127:0] rd_data;
  logic [127:0] mem [2**(MEM_AW+1)];
  logic unused_bits;
  sync_fifo #(.W(34), .DEPTH(AF_DEPTH)) u_af (
    .clk(clk), .rst(rst),
    .wr_en(bus.af_wr_en), .din({bus.af_addr_din, bus.af_cmd_din}),
    .rd_en(af_pop), .dout({af_addr, af_cmd}),
    .full(bus.af_full), .empty(af_empty), .count(af_cnt)
  );
  sync_fifo #(.W(144), .DEPTH(WDF_DEPTH)) u_wdf (
    .clk(clk), .rst(rst),
    .wr_en(bus.wdf_wr_en), .din({bus.wdf_din, bus.wdf_mask_din}),
    .rd_en(wdf_pop), .dout({wdf_data, wdf_mask}),
    .full(bus.wdf_full), .empty(wdf_empty), .count(wdf_cnt)
  );
  assign unused_bits = ^{af_addr[30:MEM_AW+2], af_addr[1:0], af_cnt};
  assign af_idx = af_addr[MEM_AW+1:2];
  // a write command waits at the head until its whole burst is in the wdf
  assign af_pop = state == IDLE && !af_empty && (af_cmd != CMD_WRITE || wdf_cnt >= (WDW+1)'(BURST_BEATS));
  assign wdf_pop = (state == WR0 || state == WR1) && !wdf_empty;
  assign bus.rdf_valid = rd_valid;
  assign bus.rdf_dout = rd_data;
  always_ff @(posedge clk)
    if (wdf_pop)
      for (int i = 0; i < 16; i++)
        if (!wdf_mask[i]) mem[{idx, state == WR1}][8*i +: 8] <= wdf_data[8*i +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: if (af_pop) begin
          idx <= af_idx;
          if (af_cmd == CMD_WRITE) state <= WR0;
          else if (af_cmd == CMD_READ && RD_LATENCY == 1) begin
            state <= RD0;
            rd_valid <= 1'b1;
            rd_data <= mem[{af_idx, 1'b0}];
          end else if (af_cmd == CMD_READ) begin
            state <= RD_WAIT;
            cnt <= CW'(RD_LATENCY - 2);
          end
        end
        WR0: state <= WR1;
        WR1: state <= IDLE;
        RD_WAIT: if (cnt == '0) begin
          state <= RD0;
          rd_valid <= 1'b1;
          rd_data <= mem[{idx, 1'b0}];
        end else cnt <= cnt - CW'(1);
        RD0: if (bus.rdf_rd_en) begin
          state <= RD1;
          rd_data <= mem[{idx, 1'b1}];
        end
        RD1: if (bus.rdf_rd_en) begin
          state <= IDLE;
          rd_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef DDR_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
      err_sticky <= '0;
    end else begin
      stat_wr_bursts <= stat_wr_bursts + 32'(state == WR1);
      stat_rd_bursts <= stat_rd_bursts + 32'(state == RD1 && bus.rdf_rd_en);
      err_sticky <= err_sticky | {af_pop && af_cmd != CMD_WRITE && af_cmd != CMD_READ,
                                  bus.wdf_wr_en && bus.wdf_full, bus.af_wr_en && bus.af_full};
    end
`endif
endmodule

// File: tb/tb_ddr_responder.sv
// tb_ddr_responder: directed protocol checks plus random bursts against a burst-level memory model
module tb_ddr_responder;
  import ddr_resp_pkg::*;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ddr_responder_if bus();
`ifdef DDR_RESP_STATS_EN
  logic [31:0] stat_wr_bursts, stat_rd_bursts;
  logic [2:0] err_sticky;
`endif
  ddr_responder #(.RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef DDR_RESP_STATS_EN
    , .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts), .err_sticky(err_sticky)
`endif
  );
  int n_chk = 0, n_err = 0;
  logic [127:0] ref_mem [1024][2];
  logic [127:0] exp_q [$];
  bit auto_rd = 1'b0, man_rd = 1'b0;
  logic [9:0] pool [8] = '{10'd0, 10'd1, 10'd2, 10'd5, 10'd341, 10'd682, 10'd1023, 10'd512};
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [30:0] mk_addr(logic [9:0] i);
    return {19'($urandom), i, 2'($urandom)};
  endfunction
  function automatic void model_wr(logic [9:0] i, int b, logic [127:0] d, logic [15:0] m);
    for (int k = 0; k < 16; k++)
      if (!m[k]) ref_mem[i][b][8*k +: 8] = d[8*k +: 8];
  endfunction
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_cmd(logic [30:0] a, logic [2:0] c);
    int w = 0;
    while (bus.af_full && w < 500) begin
      tick();
      w++;
    end
    check("af_wait", 128'(w < 500), 128'(1));
    bus.af_addr_din = a;
    bus.af_cmd_din = c;
    bus.af_wr_en = 1'b1;
    tick();
    bus.af_wr_en = 1'b0;
  endtask
  task automatic push_beat(logic [127:0] d, logic [15:0] m);
    int w = 0;
    while (bus.wdf_full && w < 500) begin
      tick();
      w++;
    end
    check("wdf_wait", 128'(w < 500), 128'(1));
    bus.wdf_din = d;
    bus.wdf_mask_din = m;
    bus.wdf_wr_en = 1'b1;
    tick();
    bus.wdf_wr_en = 1'b0;
  endtask
  task automatic write_burst(logic [30:0] a, logic [127:0] d0, logic [127:0] d1,
                             logic [15:0] m0, logic [15:0] m1, bit beats_first);
    if (!beats_first) push_cmd(a, CMD_WRITE);
    push_beat(d0, m0);
    push_beat(d1, m1);
    if (beats_first) push_cmd(a, CMD_WRITE);
    model_wr(a[11:2], 0, d0, m0);
    model_wr(a[11:2], 1, d1, m1);
  endtask
  task automatic read_burst(logic [30:0] a);
    exp_q.push_back(ref_mem[a[11:2]][0]);
    exp_q.push_back(ref_mem[a[11:2]][1]);
    push_cmd(a, CMD_READ);
  endtask
  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      tick();
      w++;
    end
    check("drain", 128'(exp_q.size()), 128'(0));
    tick(4);
  endtask
  task automatic wait_valid();
    int w = 0;
    while (!bus.rdf_valid && w < 100) begin
      tick();
      w++;
    end
    check("valid_wait", 128'(bus.rdf_valid), 128'(1));
  endtask
  // read-side consumer: drives rdf_rd_en at negedges and checks every consumed beat in order
  initial begin
    bus.rdf_rd_en = 1'b0;
    forever begin
      @(negedge clk);
      bus.rdf_rd_en = auto_rd ? ($urandom_range(0, 9) < 7) : man_rd;
      if (rst && bus.rdf_valid && bus.rdf_rd_en) begin
        if (exp_q.size() == 0) check("rdf_extra", 128'(1), 128'(0));
        else check("rdf_data", bus.rdf_dout, exp_q.pop_front());
      end
    end
  end
  initial begin
    logic [30:0] a;
    logic [127:0] d0, d1, hold;
    int n;
    bus.af_wr_en = 1'b0;
    bus.wdf_wr_en = 1'b0;
    bus.af_addr_din = '0;
    bus.af_cmd_din = '0;
    bus.wdf_din = '0;
    bus.wdf_mask_din = '0;
    tick(3);
    check("rst_af_full", 128'(bus.af_full), 128'(0));
    check("rst_wdf_full", 128'(bus.wdf_full), 128'(0));
    check("rst_rdf_valid", 128'(bus.rdf_valid), 128'(0));
    check("rst_rdf_dout", bus.rdf_dout, 128'(0));
    rst = 1'b1;
    tick(2);
    man_rd = 1'b1;
    foreach (pool[p]) write_burst(mk_addr(pool[p]), rand128(), rand128(), 16'h0, 16'h0, 1'b0);
    tick(6);
    // round trip at address 4 with latency measured from the capture edge of the read push
    d0 = 128'h0200ff00_11223344_55667788_00ff0000;
    d1 = 128'h001a002b_0badf00d_cafebabe_000000ff;
    write_burst(31'h4, d0, d1, 16'h0, 16'h0, 1'b0);
    tick(6);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    push_cmd(31'h4, CMD_READ);
    n = 0;
    while (!bus.rdf_valid && n < 20) begin
      tick();
      n++;
    end
    check("rd_latency", 128'(n), 128'(L));
    check("rt_beat0", bus.rdf_dout, d0);
    tick();
    check("b2b_valid", 128'(bus.rdf_valid), 128'(1));
    check("b2b_beat1", bus.rdf_dout, d1);
    tick();
    check("b2b_done", 128'(bus.rdf_valid), 128'(0));
    wait_drain();
    // byte mask: only bytes 0..3 take the second write
    a = mk_addr(pool[3]);
    write_burst(a, '1, '1, 16'h0, 16'h0, 1'b0);
    write_burst(a, '0, '0, 16'hfff0, 16'hfff0, 1'b1);
    exp_q.push_back({96'hffff_ffff_ffff_ffff_ffff_ffff, 32'h0});
    exp_q.push_back({96'hffff_ffff_ffff_ffff_ffff_ffff, 32'h0});
    push_cmd(a, CMD_READ);
    wait_drain();
    // write command ahead of its beats, read queued behind it must stall
    a = mk_addr(pool[2]);
    d0 = rand128();
    d1 = rand128();
    push_cmd(a, CMD_WRITE);
    model_wr(a[11:2], 0, d0, 16'h0);
    model_wr(a[11:2], 1, d1, 16'h0);
    read_burst(a);
    tick(5);
    check("late_stall", 128'(bus.rdf_valid), 128'(0));
    push_beat(d0, 16'h0);
    push_beat(d1, 16'h0);
    wait_drain();
    check("late_data", ref_mem[a[11:2]][0], d0);
    // af full: first read is popped and parks in RD0, the next eight fill the FIFO
    man_rd = 1'b0;
    tick(2);
    for (int k = 0; k < 9; k++) begin
      read_burst(mk_addr(pool[k % 8]));
      if (k >= 7) check($sformatf("af_full_push%0d", k + 1), 128'(bus.af_full), 128'(k == 8));
    end
    bus.af_addr_din = mk_addr(pool[0]);
    bus.af_cmd_din = CMD_READ;
    bus.af_wr_en = 1'b1;
    tick();
    bus.af_wr_en = 1'b0;
    check("af_full_drop", 128'(bus.af_full), 128'(1));
`ifdef DDR_RESP_STATS_EN
    check("err_af", 128'(err_sticky[0]), 128'(1));
`endif
    man_rd = 1'b1;
    wait_drain();
    tick(10);
    check("af_full_clear", 128'(bus.af_full), 128'(0));
    check("af_no_extra", 128'(bus.rdf_valid), 128'(0));
    // backpressure: beat 0 holds, beat 1 follows the rise of rdf_rd_en by one cycle
    man_rd = 1'b0;
    a = mk_addr(pool[4]);
    read_burst(a);
    wait_valid();
    hold = bus.rdf_dout;
    check("bp_beat0", hold, ref_mem[a[11:2]][0]);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold", {bus.rdf_valid, bus.rdf_dout[126:0]}, {1'b1, hold[126:0]});
    end
    man_rd = 1'b1;
    tick();
    check("bp_beat1", bus.rdf_dout, ref_mem[a[11:2]][1]);
    wait_drain();
    // wdf full, then async reset during RD_WAIT
    man_rd = 1'b0;
    for (int k = 0; k < 16; k++) begin
      push_beat(rand128(), 16'h0);
      if (k >= 14) check($sformatf("wdf_full_push%0d", k + 1), 128'(bus.wdf_full), 128'(k == 15));
    end
    push_cmd(mk_addr(pool[5]), CMD_READ);
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_rdf_valid", 128'(bus.rdf_valid), 128'(0));
    check("arst_af_full", 128'(bus.af_full), 128'(0));
    check("arst_wdf_full", 128'(bus.wdf_full), 128'(0));
    exp_q.delete();
    tick(2);
    rst = 1'b1;
    tick(2);
    man_rd = 1'b1;
    read_burst(31'h4);
    read_burst(mk_addr(pool[3]));
    wait_drain();
    // random mix of aliased writes, reads and invalid commands under random backpressure
    auto_rd = 1'b1;
    for (int k = 0; k < 80; k++) begin
      a = mk_addr(pool[$urandom % 8]);
      if ($urandom % 10 == 0) push_cmd(a, 3'($urandom_range(2, 7)));
      else if ($urandom % 2 == 0)
        write_burst(a, rand128(), rand128(), ($urandom % 3 == 0) ? 16'($urandom) : 16'h0,
                    ($urandom % 3 == 0) ? 16'($urandom) : 16'h0, 1'($urandom));
      else read_burst(a);
    end
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
